// File: rtl/hdlc_chk_pkg.sv
// Shared types and constants for the HDLC receive-stream checker.
package hdlc_chk_pkg;

  typedef enum logic [1:0] {
    ST_HUNT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_FRAME = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    ERR_NONE  = 3'd0,
    ERR_ABORT = 3'd1,
    ERR_SHORT = 3'd2,
    ERR_LONG  = 3'd3,
    ERR_ALIGN = 3'd4,
    ERR_FCS   = 3'd5
  } err_code_e;

  localparam logic [7:0]  FLAG_PAT = 8'h7E;
  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;
  localparam logic [15:0] CRC_GOOD = 16'hF0B8;

  // Bit-reverse a 16-bit word (used to derive the LSB-first polynomial).
  function automatic logic [15:0] reflect16(input logic [15:0] v);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = v[15-i];
    return r;
  endfunction

endpackage

// File: rtl/hdlc_crc16_serial.sv
// Serial reflected CRC-16-CCITT, one bit per enabled cycle, with synchronous preset.
module hdlc_crc16_serial
  import hdlc_chk_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        preset_i,
  input  logic        en_i,
  input  logic        bit_i,
  output logic [15:0] crc_o
);

  logic [15:0] crc_q, crc_d;
  logic        fb;

  assign fb = crc_q[0] ^ bit_i;

  always_comb begin
    crc_d = crc_q;
    if (preset_i) begin
      crc_d = CRC_INIT;
    end else if (en_i) begin
      crc_d = {1'b0, crc_q[15:1]} ^ (fb ? reflect16(CRC_POLY) : 16'h0000);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) crc_q <= '0;
    else         crc_q <= crc_d;
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/hdlc_rx_stream_checker.sv
// Always-on HDLC receive-stream checker: flag/abort detection, destuffing, frame
// classification and saturating statistics. Define HDLC_CHK_FCS_EN to add the FCS check.
module hdlc_rx_stream_checker
  import hdlc_chk_pkg::*;
#(
  parameter int MIN_LEN    = 2,
  parameter int MAX_LEN    = 256,
  parameter int LEN_W      = 9,
  parameter int CNT_W      = 16,
  parameter int ABORT_ONES = 7
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             bit_valid_i,
  input  logic             bit_i,
  input  logic             clr_i,
  output logic [1:0]       state_o,
  output logic             flag_det_o,
  output logic             abort_det_o,
  output logic             frame_ok_o,
  output logic             frame_err_o,
  output logic [2:0]       err_code_o,
  output logic [LEN_W-1:0] frame_len_o,
  output logic [CNT_W-1:0] frame_cnt_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic             sticky_err_o
);

  // bit_cnt is LEN_W+3 wide so that a saturated count maps to an all-ones byte length.
  localparam int BIT_W  = LEN_W + 3;
  localparam int ONES_W = 4;

  state_e             state_q, state_d;
  logic [7:0]         shift_q, shift_d;
  logic [ONES_W-1:0]  ones_q, ones_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic               flag_q, flag_d, abort_q, abort_d, ok_q, ok_d, err_q, err_d;
  logic [2:0]         code_q, code_d, eval_code;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [CNT_W-1:0]   fcnt_q, fcnt_d, ecnt_q, ecnt_d;
  logic               sticky_q, sticky_d;

  logic [7:0]         raw_shift;
  logic               is_flag, is_abort, is_stuff, fcs_bad;
  logic [BIT_W-1:0]   frame_bits;
  logic [LEN_W-1:0]   frame_bytes;

  assign raw_shift   = {bit_i, shift_q[7:1]};
  assign is_flag     = bit_valid_i && (raw_shift == FLAG_PAT);
  assign is_abort    = bit_valid_i && bit_i && (ones_q == ONES_W'(ABORT_ONES - 1));
  assign is_stuff    = bit_valid_i && !bit_i && (ones_q == ONES_W'(5));
  assign frame_bits  = bit_cnt_q - BIT_W'(7);
  assign frame_bytes = frame_bits[BIT_W-1:3];

`ifdef HDLC_CHK_FCS_EN
  // The 7-bit delay holds back the opening bits of a closing flag so they never reach the CRC.
  logic [6:0]  dly_q, dly_d, dlv_q, dlv_d;
  logic        data_bit_en;
  logic [15:0] crc;

  assign data_bit_en = bit_valid_i && !is_stuff && !is_flag;

  always_comb begin
    dly_d = dly_q;
    dlv_d = dlv_q;
    if (is_flag) begin
      dlv_d = '0;
    end else if (data_bit_en) begin
      dly_d = {bit_i, dly_q[6:1]};
      dlv_d = {1'b1, dlv_q[6:1]};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dly_q <= '0;
      dlv_q <= '0;
    end else begin
      dly_q <= dly_d;
      dlv_q <= dlv_d;
    end
  end

  hdlc_crc16_serial u_crc (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .preset_i(is_flag),
    .en_i    (data_bit_en && dlv_q[0]),
    .bit_i   (dly_q[0]),
    .crc_o   (crc)
  );

  assign fcs_bad = (crc != CRC_GOOD);
`else
  assign fcs_bad = 1'b0;
`endif

  always_comb begin
    eval_code = ERR_NONE;
    if (frame_bits[2:0] != 3'd0)               eval_code = ERR_ALIGN;
    else if (frame_bytes < LEN_W'(MIN_LEN))    eval_code = ERR_SHORT;
    else if (frame_bytes > LEN_W'(MAX_LEN))    eval_code = ERR_LONG;
    else if (fcs_bad)                          eval_code = ERR_FCS;
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    ones_d    = ones_q;
    bit_cnt_d = bit_cnt_q;
    flag_d    = 1'b0;
    abort_d   = 1'b0;
    ok_d      = 1'b0;
    err_d     = 1'b0;
    code_d    = code_q;
    len_d     = len_q;
    fcnt_d    = fcnt_q;
    ecnt_d    = ecnt_q;
    sticky_d  = sticky_q;

    if (bit_valid_i) begin
      shift_d = raw_shift;
      if (!bit_i)                                  ones_d = '0;
      else if (ones_q != ONES_W'(ABORT_ONES))      ones_d = ones_q + 1'b1;
      flag_d  = is_flag;
      abort_d = is_abort;

      if (is_abort) begin
        state_d   = ST_HUNT;
        bit_cnt_d = '0;
        if (state_q == ST_FRAME) begin
          err_d  = 1'b1;
          code_d = ERR_ABORT;
        end
      end else if (is_flag) begin
        state_d   = ST_IDLE;
        bit_cnt_d = '0;
        if (state_q == ST_FRAME) begin
          len_d = frame_bytes;
          if (eval_code == ERR_NONE) begin
            ok_d = 1'b1;
            if (fcnt_q != '1) fcnt_d = fcnt_q + 1'b1;
          end else begin
            err_d  = 1'b1;
            code_d = eval_code;
          end
        end
      end else if (state_q != ST_HUNT && !is_stuff) begin
        if (bit_cnt_q != '1) bit_cnt_d = bit_cnt_q + 1'b1;
        if (state_q == ST_IDLE && bit_cnt_d == BIT_W'(8)) state_d = ST_FRAME;
      end
    end

    if (err_d) begin
      sticky_d = 1'b1;
      if (ecnt_q != '1) ecnt_d = ecnt_q + 1'b1;
    end

    // Clear overrides statistics only; pulses and err_code still reflect the event.
    if (clr_i) begin
      fcnt_d   = '0;
      ecnt_d   = '0;
      sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_HUNT;
      shift_q   <= '0;
      ones_q    <= '0;
      bit_cnt_q <= '0;
      flag_q    <= 1'b0;
      abort_q   <= 1'b0;
      ok_q      <= 1'b0;
      err_q     <= 1'b0;
      code_q    <= '0;
      len_q     <= '0;
      fcnt_q    <= '0;
      ecnt_q    <= '0;
      sticky_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      ones_q    <= ones_d;
      bit_cnt_q <= bit_cnt_d;
      flag_q    <= flag_d;
      abort_q   <= abort_d;
      ok_q      <= ok_d;
      err_q     <= err_d;
      code_q    <= code_d;
      len_q     <= len_d;
      fcnt_q    <= fcnt_d;
      ecnt_q    <= ecnt_d;
      sticky_q  <= sticky_d;
    end
  end

  assign state_o      = state_q;
  assign flag_det_o   = flag_q;
  assign abort_det_o  = abort_q;
  assign frame_ok_o   = ok_q;
  assign frame_err_o  = err_q;
  assign err_code_o   = code_q;
  assign frame_len_o  = len_q;
  assign frame_cnt_o  = fcnt_q;
  assign err_cnt_o    = ecnt_q;
  assign sticky_err_o = sticky_q;

endmodule

// File: tb/tb_hdlc_rx_stream_checker.sv
// Directed bench for hdlc_rx_stream_checker; runs the FCS vectors when HDLC_CHK_FCS_EN is defined.
module tb_hdlc_rx_stream_checker;

`ifdef HDLC_CHK_FCS_EN
  localparam int FCS_B = 2;
`else
  localparam int FCS_B = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bit_valid = 1'b0;
  logic        bit_in = 1'b0;
  logic        clr = 1'b0;
  logic [1:0]  state;
  logic        flag_det, abort_det, frame_ok, frame_err, sticky;
  logic [2:0]  err_code;
  logic [8:0]  frame_len;
  logic [15:0] frame_cnt, err_cnt;

  int n_vec = 0;
  int n_miss = 0;
  int n_flag = 0, n_abort = 0, n_ok = 0, n_err = 0;
  int b_flag, b_abort, b_ok, b_err;
  int stuff_ones = 0;

  always #5 clk = ~clk;

  hdlc_rx_stream_checker #(.MIN_LEN(2), .MAX_LEN(4), .LEN_W(9), .CNT_W(16), .ABORT_ONES(7)) dut (
    .clk_i(clk), .rst_ni(rst_n), .bit_valid_i(bit_valid), .bit_i(bit_in), .clr_i(clr),
    .state_o(state), .flag_det_o(flag_det), .abort_det_o(abort_det), .frame_ok_o(frame_ok),
    .frame_err_o(frame_err), .err_code_o(err_code), .frame_len_o(frame_len),
    .frame_cnt_o(frame_cnt), .err_cnt_o(err_cnt), .sticky_err_o(sticky)
  );

  always @(negedge clk) begin
    if (rst_n) begin
      if (flag_det)  n_flag++;
      if (abort_det) n_abort++;
      if (frame_ok)  n_ok++;
      if (frame_err) n_err++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit2(input logic b, input logic c);
    @(negedge clk);
    bit_valid = 1'b1; bit_in = b; clr = c;
    @(negedge clk);
    bit_valid = 1'b0; clr = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    send_bit2(b, 1'b0);
  endtask

  task automatic send_flag_clr(input logic c);
    send_bit(1'b0);
    repeat (6) send_bit(1'b1);
    send_bit2(1'b0, c);
    stuff_ones = 0;
  endtask

  task automatic send_flag();
    send_flag_clr(1'b0);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) begin
      send_bit(v[i]);
      if (v[i]) begin
        stuff_ones++;
        if (stuff_ones == 5) begin
          send_bit(1'b0);
          stuff_ones = 0;
        end
      end else begin
        stuff_ones = 0;
      end
    end
  endtask

  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] v);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = (r[0] ^ v[i]) ? ((r >> 1) ^ 16'h8408) : (r >> 1);
    return r;
  endfunction

  // Two data bytes, followed by their FCS when the FCS check is built in; flip corrupts byte 0.
  task automatic send_frame2(input logic [7:0] b0, input logic [7:0] b1, input logic flip);
    logic [15:0] fcs;
    fcs = ~crc_byte(crc_byte(16'hFFFF, b0), b1);
    send_byte(flip ? (b0 ^ 8'h01) : b0);
    send_byte(b1);
    if (FCS_B != 0) begin
      send_byte(fcs[7:0]);
      send_byte(fcs[15:8]);
    end
  endtask

  task automatic snap();
    b_flag = n_flag; b_abort = n_abort; b_ok = n_ok; b_err = n_err;
  endtask

  task automatic pulse_clr();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    idle(1);
  endtask

  initial begin
    idle(3);
    rst_n = 1'b1;
    idle(2);
    check_eq("rst.state", 32'(state), 32'd0);
    check_eq("rst.len", 32'(frame_len), 32'd0);
    check_eq("rst.fcnt", 32'(frame_cnt), 32'd0);
    check_eq("rst.ecnt", 32'(err_cnt), 32'd0);
    check_eq("rst.code_sticky", 32'({err_code, sticky}), 32'd0);

    // 1: back-to-back flags then A5 3C
    snap();
    send_flag(); send_flag();
    send_frame2(8'hA5, 8'h3C, 1'b0);
    send_flag(); idle(2);
    check_eq("t1.flags", 32'(n_flag - b_flag), 32'd3);
    check_eq("t1.ok", 32'(n_ok - b_ok), 32'd1);
    check_eq("t1.len", 32'(frame_len), 32'(2 + FCS_B));
    check_eq("t1.fcnt", 32'(frame_cnt), 32'd1);
    check_eq("t1.state", 32'(state), 32'd1);

    // 2: FF FF needs stuffing
    snap();
    send_flag();
    send_frame2(8'hFF, 8'hFF, 1'b0);
    send_flag(); idle(2);
    check_eq("t2.ok", 32'(n_ok - b_ok), 32'd1);
    check_eq("t2.len", 32'(frame_len), 32'(2 + FCS_B));
    check_eq("t2.abort", 32'(n_abort - b_abort), 32'd0);
    check_eq("t2.fcnt", 32'(frame_cnt), 32'd2);

    // 3: abort inside a frame
    snap();
    send_flag(); send_byte(8'hA5);
    repeat (7) send_bit(1'b1);
    idle(2);
    check_eq("t3.abort", 32'(n_abort - b_abort), 32'd1);
    check_eq("t3.err", 32'(n_err - b_err), 32'd1);
    check_eq("t3.code", 32'(err_code), 32'd1);
    check_eq("t3.state_hunt", 32'(state), 32'd0);
    check_eq("t3.ecnt", 32'(err_cnt), 32'd1);
    send_flag(); idle(2);
    check_eq("t3.state_idle", 32'(state), 32'd1);
    pulse_clr();
    check_eq("t3.clr_fcnt", 32'(frame_cnt), 32'd0);
    check_eq("t3.clr_ecnt", 32'(err_cnt), 32'd0);
    check_eq("t3.clr_code", 32'(err_code), 32'd1);

    // 4: three extra bits -> misaligned
    snap();
    send_flag(); send_byte(8'hA5); send_byte(8'h3C);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    send_flag(); idle(2);
    check_eq("t4.err", 32'(n_err - b_err), 32'd1);
    check_eq("t4.code", 32'(err_code), 32'd4);
    check_eq("t4.ecnt", 32'(err_cnt), 32'd1);
    check_eq("t4.sticky", 32'(sticky), 32'd1);
    check_eq("t4.len", 32'(frame_len), 32'd2);

    // 5: one-byte frame is short, then clear
    send_flag(); send_byte(8'hA5); send_flag(); idle(2);
    check_eq("t5.code", 32'(err_code), 32'd2);
    check_eq("t5.ecnt", 32'(err_cnt), 32'd2);
    pulse_clr();
    check_eq("t5.clr_ecnt", 32'(err_cnt), 32'd0);
    check_eq("t5.clr_sticky", 32'(sticky), 32'd0);
    check_eq("t5.clr_code", 32'(err_code), 32'd2);

    // 7: five bytes > MAX_LEN, clear coincident with closing flag
    snap();
    send_flag();
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44); send_byte(8'h55);
    send_flag_clr(1'b1); idle(2);
    check_eq("t7.err", 32'(n_err - b_err), 32'd1);
    check_eq("t7.code", 32'(err_code), 32'd3);
    check_eq("t7.len", 32'(frame_len), 32'd5);
    check_eq("t7.ecnt_clr", 32'(err_cnt), 32'd0);
    check_eq("t7.sticky_clr", 32'(sticky), 32'd0);

`ifdef HDLC_CHK_FCS_EN
    // 6: good FCS, then a corrupted data bit
    snap();
    send_flag(); send_frame2(8'h01, 8'h02, 1'b0); send_flag(); idle(2);
    check_eq("t6.ok", 32'(n_ok - b_ok), 32'd1);
    check_eq("t6.len", 32'(frame_len), 32'd4);
    send_flag(); send_frame2(8'h01, 8'h02, 1'b1); send_flag(); idle(2);
    check_eq("t6.code_fcs", 32'(err_code), 32'd5);
    check_eq("t6.ok_total", 32'(n_ok - b_ok), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
